// File: rtl/prime_checker.sv
// -----------------------------------------------------------------------------
// prime_checker
//   Sequential trial-division primality tester. It accepts one candidate n and
//   divides it by 2 and then by the odd factors 3, 5, 7, ... while f*f <= n.
//   Each division is a restoring shift-subtract that takes WIDTH cycles. The
//   result is either "prime" or "composite" together with the smallest factor.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       candidate valid
//   in_ready    out  1       high only in IDLE (and out of reset)
//   in_value    in   WIDTH   candidate n, unsigned
//   out_valid   out  1       result valid; held until out_ready
//   out_ready   in   1       sink accepts result
//   out_prime   out  1       1 = n is prime
//   out_factor  out  FWIDTH  smallest factor > 1 if composite; else 0
//   busy        out  1       high in CHECK or DIV
//   dbg_state   out  2       current FSM state (IDLE=0 CHECK=1 DIV=2 RESULT=3)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready and out_valid depend only on registered state (and rst_n), so
// no combinational path runs from in_* or out_ready to either of them. Once
// out_valid is high, it stays high with stable data until out_ready is seen.
// -----------------------------------------------------------------------------
module prime_checker #(
  parameter int WIDTH  = 32,
  parameter int FWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_prime,
  output logic [FWIDTH-1:0] out_factor,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // sqrt(n) < 2^FWIDTH must hold so that any factor found fits in out_factor.
  if (WIDTH > 2 * FWIDTH) begin : g_bad_width
    $error("prime_checker: WIDTH must be <= 2*FWIDTH");
  end

  localparam int FW1 = FWIDTH + 1;      // factor register width
  localparam int SQW = 2 * FWIDTH + 2;  // f*f register width
  localparam int RW  = FW1 + 1;         // trial remainder width
  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_DIV    = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    n_q, n_d;
  logic [FW1-1:0]      f_q, f_d;
  logic [SQW-1:0]      sq_q, sq_d;
  logic [FW1-1:0]      rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_prime_q, out_prime_d;
  logic [FWIDTH-1:0]   out_factor_q, out_factor_d;

  // One restoring-division step: shift in the next dividend bit (MSB first)
  // and subtract f if it fits. rem stays below f <= 2^FWIDTH, so the
  // difference always fits back into FW1 bits.
  logic [RW-1:0]  rem_trial;
  logic           rem_ge;
  logic [FW1-1:0] rem_next;

  always_comb begin
    rem_trial = {rem_q, n_q[cnt_q]};
    rem_ge    = (rem_trial >= RW'(f_q));
    rem_next  = FW1'(rem_ge ? (rem_trial - RW'(f_q)) : rem_trial);
  end

  // Next FSM state, datapath updates and registered outputs.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    f_d          = f_q;
    sq_d         = sq_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_prime_d  = out_prime_q;
    out_factor_d = out_factor_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          n_d = in_value;
          if (in_value < WIDTH'(2)) begin
            state_d      = S_RESULT;
            out_valid_d  = 1'b1;
            out_prime_d  = 1'b0;
            out_factor_d = '0;
          end else begin
            state_d = S_CHECK;
            f_d     = FW1'(2);
            sq_d    = SQW'(4);
          end
        end
      end

      S_CHECK: begin
        // Every candidate factor up to sqrt(n) was rejected, so n is prime.
        if (sq_q > SQW'(n_q)) begin
          state_d      = S_RESULT;
          out_valid_d  = 1'b1;
          out_prime_d  = 1'b1;
          out_factor_d = '0;
        end else begin
          state_d = S_DIV;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end

      S_DIV: begin
        rem_d = rem_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          if (rem_next == '0) begin
            state_d      = S_RESULT;
            out_valid_d  = 1'b1;
            out_prime_d  = 1'b0;
            out_factor_d = f_q[FWIDTH-1:0];
          end else begin
            state_d = S_CHECK;
            // After 2 the factors run through the odd numbers;
            // (f+2)^2 = f^2 + 4f + 4 keeps sq exact without a multiplier.
            if (f_q == FW1'(2)) begin
              f_d  = FW1'(3);
              sq_d = SQW'(9);
            end else begin
              f_d  = f_q + FW1'(2);
              sq_d = sq_q + (SQW'(f_q) << 2) + SQW'(4);
            end
          end
        end
      end

      S_RESULT: begin
        if (out_ready) begin
          state_d      = S_IDLE;
          out_valid_d  = 1'b0;
          out_prime_d  = 1'b0;
          out_factor_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      f_q          <= '0;
      sq_q         <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_prime_q  <= 1'b0;
      out_factor_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      f_q          <= f_d;
      sq_q         <= sq_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_prime_q  <= out_prime_d;
      out_factor_q <= out_factor_d;
    end
  end

  // in_ready is forced low while reset is asserted so every output reads 0
  // during reset; it rises as soon as rst_n is released in IDLE.
  assign in_ready   = (state_q == S_IDLE) && rst_n;
  assign busy       = (state_q == S_CHECK) || (state_q == S_DIV);
  assign out_valid  = out_valid_q;
  assign out_prime  = out_prime_q;
  assign out_factor = out_factor_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_prime_checker.sv
// -----------------------------------------------------------------------------
// tb_prime_checker
//   Directed-vector bench for prime_checker (WIDTH=32, FWIDTH=16). Expected
//   primality, smallest factor and latency are hand-computed constants.
//   Latency is counted in rising edges, the accept edge being edge 1.
// -----------------------------------------------------------------------------
module tb_prime_checker;

  localparam int WIDTH  = 32;
  localparam int FWIDTH = 16;
  localparam int BUDGET = 30000;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_value;
  logic              out_valid;
  logic              out_ready;
  logic              out_prime;
  logic [FWIDTH-1:0] out_factor;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: {prime, factor} pushed when a candidate is sent.
  logic [FWIDTH:0] exp_q[$];

  prime_checker #(.WIDTH(WIDTH), .FWIDTH(FWIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prime  (out_prime),
    .out_factor (out_factor),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present n for one edge (the DUT is expected to be in IDLE).
  task automatic send(input logic [WIDTH-1:0] n);
    chk("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    in_value = n;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_value = '0;
  endtask

  // Called #1 after the accept edge; returns edges until out_valid (accept = 1).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("result_timeout", (lat >= BUDGET), 0);
  endtask

  task automatic run_vec(input string tag, input logic [WIDTH-1:0] n,
                         input logic exp_prime, input logic [FWIDTH-1:0] exp_factor,
                         input int exp_lat);
    int lat;
    logic [FWIDTH:0] e;
    exp_q.push_back({exp_prime, exp_factor});
    send(n);
    wait_result(lat);
    e = exp_q.pop_front();
    chk({tag, "_prime"},  out_prime,  e[FWIDTH]);
    chk({tag, "_factor"}, out_factor, e[FWIDTH-1:0]);
    if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
    // out_ready is high, so the result drains on the next edge.
    @(posedge clk); #1;
    chk({tag, "_drained"}, {out_valid, in_ready, out_prime}, 3'b010);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {in_ready, out_valid, out_prime, out_factor, busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", in_ready, 1);
    chk("rst_release_idle", {out_valid, busy, dbg_state}, '0);

    // Trivial and smallest cases
    run_vec("n0",  0, 1'b0, 0, 1);
    run_vec("n1",  1, 1'b0, 0, 1);
    run_vec("n2",  2, 1'b1, 0, 2);
    run_vec("n3",  3, 1'b1, 0, 2);
    run_vec("n4",  4, 1'b0, 2, 34);
    run_vec("n7",  7, 1'b1, 0, 35);
    run_vec("n9",  9, 1'b0, 3, 67);
    run_vec("n25", 25, 1'b0, 5, 100);

    // Larger candidates that stay inside the cycle budget
    run_vec("n1e9p8",   32'd1000000008, 1'b0, 2, 34);
    run_vec("nmax",     32'd4294967295, 1'b0, 3, 67);
    run_vec("nmaxm1",   32'd4294967294, 1'b0, 2, 34);
    run_vec("n509",     509,            1'b1, 0, 0);
    run_vec("n1009",    1009,           1'b1, 0, 0);
    run_vec("n63001",   63001,          1'b0, 251, 0);
    run_vec("n65521",   65521,          1'b1, 0, 0);
    run_vec("n1000003", 32'd1000003,    1'b1, 0, 0);

    // Back-pressure: result held for 10 cycles, new candidate refused
    out_ready = 1'b0;
    send(15);
    wait_result(lat);
    chk("hold_latency", lat, 67);
    in_valid = 1'b1;
    in_value = 2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {out_valid, out_prime, out_factor, in_ready, busy},
          {1'b1, 1'b0, 16'd3, 1'b0, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {out_valid, out_prime, out_factor, in_ready, busy, dbg_state},
        {1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 2'd0});
    run_vec("after_hold_n2", 2, 1'b1, 0, 2);

    // Asynchronous reset in the middle of a division
    send(32'd4294967291);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_div_state", dbg_state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {in_ready, out_valid, out_prime, out_factor, busy, dbg_state}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", {out_valid, busy}, 2'b00);
    end
    run_vec("post_rst_n7", 7, 1'b1, 0, 35);

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
